// File: rtl/word_serializer.sv
// Parallel-in/serial-out reader for the storage register word.
// Optional even-parity trailer bit: define WORD_SERIALIZER_PARITY_EN.
module word_serializer #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

`ifdef WORD_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             load_ready_q;
    logic             ser_valid_q;
    logic             ser_out_q;
    logic             ser_last_q;
    logic             busy_q;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic             parity_q;
`endif

    logic handshake;
    logic at_last;
    logic load_hs;
    logic load_head;
    logic next_head;

    assign handshake = ser_valid_q & ser_ready;
    assign at_last   = (count_q == LAST_IDX);
    assign load_hs   = load_ready_q & load_valid;

    // Advance the shift register by one bit in the configured direction
    always_comb begin
        shift_d = shift_q;
        if (MSB_FIRST) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            shift_d = {1'b0, shift_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
    end

    // Bit presented first from a fresh word, and next bit after a shift
    always_comb begin
        load_head = MSB_FIRST ? d[WIDTH-1] : d[0];
        next_head = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
    end

    // Control FSM with all handshake outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            count_q      <= '0;
            load_ready_q <= 1'b1;
            ser_valid_q  <= 1'b0;
            ser_out_q    <= 1'b0;
            ser_last_q   <= 1'b0;
            busy_q       <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_hs) begin
                        state_q      <= SHIFT;
                        shift_q      <= d;
                        count_q      <= '0;
                        load_ready_q <= 1'b0;
                        ser_valid_q  <= 1'b1;
                        ser_out_q    <= load_head;
                        ser_last_q   <= 1'b0;
                        busy_q       <= 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
                        parity_q     <= ^d;
`endif
                    end
                end
                SHIFT: begin
                    if (handshake) begin
                        if (at_last) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                            state_q    <= PARITY;
                            shift_q    <= '0;
                            ser_out_q  <= parity_q;
                            ser_last_q <= 1'b1;
`else
                            state_q      <= IDLE;
                            shift_q      <= '0;
                            count_q      <= '0;
                            load_ready_q <= 1'b1;
                            ser_valid_q  <= 1'b0;
                            ser_out_q    <= 1'b0;
                            ser_last_q   <= 1'b0;
                            busy_q       <= 1'b0;
`endif
                        end else begin
                            shift_q   <= shift_d;
                            count_q   <= count_d;
                            ser_out_q <= next_head;
`ifdef WORD_SERIALIZER_PARITY_EN
                            ser_last_q <= 1'b0;
`else
                            ser_last_q <= (count_q == PRE_LAST);
`endif
                        end
                    end
                end
`ifdef WORD_SERIALIZER_PARITY_EN
                PARITY: begin
                    if (handshake) begin
                        state_q      <= IDLE;
                        count_q      <= '0;
                        load_ready_q <= 1'b1;
                        ser_valid_q  <= 1'b0;
                        ser_out_q    <= 1'b0;
                        ser_last_q   <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q      <= IDLE;
                    load_ready_q <= 1'b1;
                    ser_valid_q  <= 1'b0;
                    ser_out_q    <= 1'b0;
                    ser_last_q   <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = load_ready_q;
    assign ser_valid  = ser_valid_q;
    assign ser_out    = ser_out_q;
    assign ser_last   = ser_last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: MSB-first and LSB-first instances.
// Parity trailer expectations follow WORD_SERIALIZER_PARITY_EN.
module tb_word_serializer;

    logic        clk;
    logic        reset;
    logic [31:0] d;
    logic        lv;
    logic        rdy;
    logic        sel;

    logic m_lr, m_out, m_val, m_last, m_busy;
    logic l_lr, l_out, l_val, l_last, l_busy;
    logic lv_m, lv_l;

    logic o_lr, o_out, o_val, o_last, o_busy;

    int checks = 0;
    int errs   = 0;
    bit exp_q[$];

    assign lv_m = lv & sel;
    assign lv_l = lv & ~sel;

    assign o_lr   = sel ? m_lr   : l_lr;
    assign o_out  = sel ? m_out  : l_out;
    assign o_val  = sel ? m_val  : l_val;
    assign o_last = sel ? m_last : l_last;
    assign o_busy = sel ? m_busy : l_busy;

    word_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .d(d),
        .load_valid(lv_m), .load_ready(m_lr),
        .ser_out(m_out), .ser_valid(m_val),
        .ser_ready(rdy), .ser_last(m_last), .busy(m_busy)
    );

    word_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .d(d),
        .load_valid(lv_l), .load_ready(l_lr),
        .ser_out(l_out), .ser_valid(l_val),
        .ser_ready(rdy), .ser_last(l_last), .busy(l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_load_ready"}, {31'd0, o_lr}, 32'd1);
        check({tag, "_ser_valid"}, {31'd0, o_val}, 32'd0);
        check({tag, "_ser_out"}, {31'd0, o_out}, 32'd0);
        check({tag, "_ser_last"}, {31'd0, o_last}, 32'd0);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic run_frame(input bit msb, input logic [31:0] w,
                             input int stall_at, input int stall_len,
                             input int poke_at, input int abort_at);
        int idx;
        int stalled;
        int budget;
        bit e;
        sel = msb;
        rdy = 1'b1;
        @(negedge clk);
        check("pre_load_ready", {31'd0, o_lr}, 32'd1);
        d  = w;
        lv = 1'b1;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(msb ? w[31-i] : w[i]);
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        exp_q.push_back(^w);
`endif
        @(negedge clk);
        lv = 1'b0;
        idx = 0;
        stalled = 0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 400) begin
            budget++;
            if (idx == abort_at) begin
                reset = 1'b0;
                #1;
                check_idle("abort");
                exp_q.delete();
                repeat (2) @(negedge clk);
                reset = 1'b1;
                return;
            end
            check("frame_valid", {31'd0, o_val}, 32'd1);
            check("frame_busy", {31'd0, o_busy}, 32'd1);
            check("frame_lr", {31'd0, o_lr}, 32'd0);
            if (idx == poke_at) begin
                d  = 32'hFFFF_FFFF;
                lv = 1'b1;
            end else begin
                lv = 1'b0;
            end
            if (idx == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
                check("hold_bit", {31'd0, o_out}, {31'd0, exp_q[0]});
                check("hold_last", {31'd0, o_last},
                      {31'd0, exp_q.size() == 1});
            end else begin
                rdy = 1'b1;
                e = exp_q.pop_front();
                check("bit", {31'd0, o_out}, {31'd0, e});
                check("last", {31'd0, o_last},
                      {31'd0, exp_q.size() == 0});
                idx++;
            end
            @(negedge clk);
        end
        lv  = 1'b0;
        rdy = 1'b1;
        check("frame_done", exp_q.size(), 32'd0);
        exp_q.delete();
        check_idle("post_frame");
    endtask

    initial begin
        reset = 1'b0;
        d     = '0;
        lv    = 1'b0;
        rdy   = 1'b0;
        sel   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sel = 1'b1;
        check_idle("reset_msb");
        sel = 1'b0;
        check_idle("reset_lsb");

        run_frame(1'b1, 32'h8000_0001, -1, 0, -1, -1);
        run_frame(1'b0, 32'h0000_00F0, -1, 0, -1, -1);
        run_frame(1'b1, 32'hA5A5_A5A5, 10, 5, -1, -1);
        run_frame(1'b1, 32'h0F0F_3C3C, -1, 0, 8, -1);
        run_frame(1'b1, 32'hDEAD_BEEF, -1, 0, -1, 17);
        run_frame(1'b1, 32'h1234_5678, -1, 0, -1, -1);
        run_frame(1'b0, 32'h1234_5678, 3, 2, -1, -1);
`ifdef WORD_SERIALIZER_PARITY_EN
        run_frame(1'b1, 32'h0000_0007, -1, 0, -1, -1);
        run_frame(1'b1, 32'h0000_0003, 32, 3, -1, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
